// File: rtl/fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_buffer
// Summary  : Single-clock elastic FIFO with registered EMPTY/FULL flags.
//            Define FIFO_BUFFER_FWFT_EN for first-word fall-through output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             WR,
    input  logic             RD,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             EMPTY,
    output logic             FULL
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             empty_q, full_q;
    logic             rd_ok, wr_ok;

    // A write into a full FIFO is allowed only when a read frees a slot this cycle.
    always_comb begin
        rd_ok = EN & RD & ~empty_q;
        wr_ok = EN & WR & (~full_q | rd_ok);
        wp_d  = wr_ok ? wp_q + AW'(1) : wp_q;
        rp_d  = rd_ok ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == C_DEPTH);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_ok) begin
            mem_q[wp_q] <= dataIn;
        end
    end

`ifdef FIFO_BUFFER_FWFT_EN
    assign dataOut = empty_q ? '0 : mem_q[rp_q];
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem_q[rp_q];
        end
    end

    assign dataOut = dout_q;
`endif

    assign EMPTY = empty_q;
    assign FULL  = full_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_buffer
// Summary  : Randomised self-checking bench for fifo_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             EN = 1'b0;
    logic             WR = 1'b0;
    logic             RD = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic [WIDTH-1:0] dataOut;
    logic             EMPTY;
    logic             FULL;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;

    fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .RD(RD),
        .dataIn(dataIn), .dataOut(dataOut), .EMPTY(EMPTY), .FULL(FULL)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2ms;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    // Applies one clock of stimulus and advances the queue model.
    task automatic cycle(input logic rst, input logic en, input logic wr,
                         input logic rd, input logic [WIDTH-1:0] din);
        logic r_ok, w_ok;
        @(negedge Clk);
        Rst = rst; EN = en; WR = wr; RD = rd; dataIn = din;
        @(posedge Clk);
        if (rst) begin
            q.delete();
            m_dout = '0;
        end else begin
            r_ok = en && rd && (q.size() != 0);
            w_ok = en && wr && ((q.size() < DEPTH) || r_ok);
            if (r_ok) m_dout = q.pop_front();
            if (w_ok) q.push_back(din);
        end
`ifdef FIFO_BUFFER_FWFT_EN
        m_dout = (q.size() != 0) ? q[0] : '0;
`endif
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({dataOut, EMPTY, FULL} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: got dout=%h empty=%b full=%b, want dout=0 empty=1 full=0",
                     dataOut, EMPTY, FULL);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, WIDTH'(i));
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({dataOut, EMPTY, FULL} !== {m_dout, 1'b0, (i == DEPTH)}) begin
                errors++;
                $display("FAIL fill[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=0 full=%b",
                         i, dataOut, EMPTY, FULL, m_dout, (i == DEPTH));
            end
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd99);
        checks++;
        if ({EMPTY, FULL} !== 2'b01 || q.size() != DEPTH) begin
            errors++;
            $display("FAIL fill_overflow: got empty=%b full=%b, want empty=0 full=1", EMPTY, FULL);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
            checks++;
`ifdef FIFO_BUFFER_FWFT_EN
            if ({dataOut, EMPTY, FULL} !== {m_dout, (i == DEPTH), 1'b0}) begin
`else
            if ({dataOut, EMPTY, FULL} !== {WIDTH'(i), (i == DEPTH), 1'b0}) begin
`endif
                errors++;
                $display("FAIL drain[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=%b full=0",
                         i, dataOut, EMPTY, FULL, m_dout, (i == DEPTH));
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        checks++;
        if ({dataOut, EMPTY, FULL} !== {m_dout, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drain_underflow: got dout=%h empty=%b full=%b, want dout=%h empty=1 full=0",
                     dataOut, EMPTY, FULL, m_dout);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v;
        v = $urandom;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, v + WIDTH'(i));
        for (int i = 5; i < 45; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, v + WIDTH'(i));
            checks++;
            if ({dataOut, EMPTY, FULL} !== {v + WIDTH'(i - 5), 1'b0, 1'b0} || q.size() != 5) begin
                errors++;
                $display("FAIL wrap[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=0 full=0",
                         i, dataOut, EMPTY, FULL, v + WIDTH'(i - 5));
            end
        end
        while (q.size() != 0) cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, $urandom);
            checks++;
            if ({dataOut, EMPTY, FULL} !== {m_dout, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=0 full=0",
                         i, dataOut, EMPTY, FULL, m_dout);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
            checks++;
            if ({dataOut, EMPTY, FULL} !== {m_dout, (i == 2), 1'b0}) begin
                errors++;
                $display("FAIL enable_drain[%0d]: got dout=%h empty=%b, want dout=%h empty=%b",
                         i, dataOut, EMPTY, m_dout, (i == 2));
            end
        end
    endtask

    task automatic test_full_simul_reset();
        logic [WIDTH-1:0] nv;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, $urandom);
            checks++;
            if ({dataOut, EMPTY, FULL} !== {m_dout, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL full_simul[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=0 full=1",
                         i, dataOut, EMPTY, FULL, m_dout);
            end
        end
        for (int i = 0; i < DEPTH - 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, $urandom);
        checks++;
        if ({dataOut, EMPTY, FULL} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: got dout=%h empty=%b full=%b, want dout=0 empty=1 full=0",
                     dataOut, EMPTY, FULL);
        end
        nv = $urandom;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, nv);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        checks++;
        if ({dataOut, EMPTY, FULL} !== {nv, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_rw: got dout=%h empty=%b, want dout=%h empty=1", dataOut, EMPTY, nv);
        end
    endtask

    task automatic test_random();
        logic r, e, w, d;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 99) < ((i / 250) % 2 ? 35 : 65));
            d = ($urandom_range(0, 99) < ((i / 250) % 2 ? 65 : 35));
            cycle(r, e, w, d, $urandom);
            checks++;
            if ({dataOut, EMPTY, FULL} !== {m_dout, (q.size() == 0), (q.size() == DEPTH)}) begin
                errors++;
                $display("FAIL random[%0d]: got dout=%h empty=%b full=%b, want dout=%h empty=%b full=%b",
                         i, dataOut, EMPTY, FULL, m_dout, (q.size() == 0), (q.size() == DEPTH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_enable();
        test_full_simul_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
